alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_if.sv | 55 +++++
 rtl/alu_issue_ctrl.sv | 107 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Issue/broadcast bundle between two reservation stations, the shared ALU
// and the result bus. The DUT uses the slave modport.
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef ALU_SRC1_SEL
`define ALU_SRC1_SEL 2
`endif
`ifndef ALU_SRC2_SEL
`define ALU_SRC2_SEL 2
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

interface alu_issue_ctrl_if #(parameter int TAG_W = 6);
  logic                        i_req0, i_req1;
  logic [`ALU_OP_SEL-1:0]      i_op0, i_op1;
  logic [`ALU_SRC1_SEL-1:0]    i_s1sel0, i_s1sel1;
  logic [`ALU_SRC2_SEL-1:0]    i_s2sel0, i_s2sel1;
  logic [`RV32_DATA_WIDTH-1:0] i_rs10, i_rs11, i_rs20, i_rs21, i_imm0, i_imm1;
  logic [`RV32_PC_WIDTH-1:0]   i_pc0, i_pc1;
  logic [TAG_W-1:0]            i_tag0, i_tag1;
  logic                        o_gnt0, o_gnt1;
  logic                        o_alu_vld;
  logic [`ALU_OP_SEL-1:0]      o_alu_op;
  logic [`ALU_SRC1_SEL-1:0]    o_alu_s1sel;
  logic [`ALU_SRC2_SEL-1:0]    o_alu_s2sel;
  logic [`RV32_DATA_WIDTH-1:0] o_alu_rs1, o_alu_rs2, o_alu_imm;
  logic [`RV32_PC_WIDTH-1:0]   o_alu_pc;
  logic [`RV32_DATA_WIDTH-1:0] i_alu_res;
  logic                        o_cdb_vld;
  logic [TAG_W-1:0]            o_cdb_tag;
  logic [`RV32_DATA_WIDTH-1:0] o_cdb_data;
  logic                        i_cdb_rdy;
  logic                        i_flush;

  modport slave (
    input  i_req0, i_req1, i_op0, i_op1, i_s1sel0, i_s1sel1, i_s2sel0, i_s2sel1,
           i_rs10, i_rs11, i_rs20, i_rs21, i_imm0, i_imm1, i_pc0, i_pc1,
           i_tag0, i_tag1, i_alu_res, i_cdb_rdy, i_flush,
    output o_gnt0, o_gnt1, o_alu_vld, o_alu_op, o_alu_s1sel, o_alu_s2sel,
           o_alu_rs1, o_alu_rs2, o_alu_imm, o_alu_pc, o_cdb_vld, o_cdb_tag, o_cdb_data
  );
  modport master (
    output i_req0, i_req1, i_op0, i_op1, i_s1sel0, i_s1sel1, i_s2sel0, i_s2sel1,
           i_rs10, i_rs11, i_rs20, i_rs21, i_imm0, i_imm1, i_pc0, i_pc1,
           i_tag0, i_tag1, i_alu_res, i_cdb_rdy, i_flush,
    input  o_gnt0, o_gnt1, o_alu_vld, o_alu_op, o_alu_s1sel, o_alu_s2sel,
           o_alu_rs1, o_alu_rs2, o_alu_imm, o_alu_pc, o_cdb_vld, o_cdb_tag, o_cdb_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-requester round-robin issue into a single-cycle ALU, with a 2-entry
// result FIFO feeding a valid/ready result broadcast.
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef ALU_SRC1_SEL
`define ALU_SRC1_SEL 2
`endif
`ifndef ALU_SRC2_SEL
`define ALU_SRC2_SEL 2
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module alu_issue_ctrl #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 2   // pointers are 1 bit wide: only 2 is supported
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus
);
  localparam int DW = `RV32_DATA_WIDTH;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } ent_t;

  ent_t                        mem_q [DEPTH];
  logic [1:0]                  cnt_q, cnt_d;
  logic                        rd_q, wr_q, ptr_q, alu_vld_q;
  logic [TAG_W-1:0]            tag_q;
  logic [`ALU_OP_SEL-1:0]      op_q;
  logic [`ALU_SRC1_SEL-1:0]    s1sel_q;
  logic [`ALU_SRC2_SEL-1:0]    s2sel_q;
  logic [DW-1:0]               rs1_q, rs2_q, imm_q;
  logic [`RV32_PC_WIDTH-1:0]   pc_q;
  logic                        push, pop, gnt_ok, gnt0, gnt1, cdb_vld;
  logic [2:0]                  occ;

  // Occupancy counts the in-flight ALU result so a grant can never land in a full buffer.
  always_comb begin
    cdb_vld = (cnt_q != 2'd0) & ~rst;
    push    = alu_vld_q;
    pop     = cdb_vld & bus.i_cdb_rdy;
    occ     = {1'b0, cnt_q} + {2'b0, push} - {2'b0, pop};
    gnt_ok  = ~rst & ~bus.i_flush & (occ < 3'(DEPTH));
    gnt0    = gnt_ok & bus.i_req0 & (~bus.i_req1 | ~ptr_q);
    gnt1    = gnt_ok & bus.i_req1 & (~bus.i_req0 | ptr_q);
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_vld_q <= 1'b0;
      cnt_q     <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ptr_q     <= 1'b0;
    end else if (bus.i_flush) begin
      alu_vld_q <= 1'b0;
      cnt_q     <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      alu_vld_q <= gnt0 | gnt1;
      cnt_q     <= cnt_d;
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      if (gnt0 | gnt1) ptr_q <= gnt0;
    end
  end

  // Payload and buffer storage carry no reset; validity lives in the control state.
  always_ff @(posedge clk) begin
    if (gnt0 | gnt1) begin
      tag_q   <= gnt1 ? bus.i_tag1   : bus.i_tag0;
      op_q    <= gnt1 ? bus.i_op1    : bus.i_op0;
      s1sel_q <= gnt1 ? bus.i_s1sel1 : bus.i_s1sel0;
      s2sel_q <= gnt1 ? bus.i_s2sel1 : bus.i_s2sel0;
      rs1_q   <= gnt1 ? bus.i_rs11   : bus.i_rs10;
      rs2_q   <= gnt1 ? bus.i_rs21   : bus.i_rs20;
      imm_q   <= gnt1 ? bus.i_imm1   : bus.i_imm0;
      pc_q    <= gnt1 ? bus.i_pc1    : bus.i_pc0;
    end
    if (push) mem_q[wr_q] <= {tag_q, bus.i_alu_res};
  end

  assign bus.o_gnt0      = gnt0;
  assign bus.o_gnt1      = gnt1;
  assign bus.o_alu_vld   = alu_vld_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_alu_s1sel = s1sel_q;
  assign bus.o_alu_s2sel = s2sel_q;
  assign bus.o_alu_rs1   = rs1_q;
  assign bus.o_alu_rs2   = rs2_q;
  assign bus.o_alu_imm   = imm_q;
  assign bus.o_alu_pc    = pc_q;
  assign bus.o_cdb_vld   = cdb_vld;
  assign bus.o_cdb_tag   = mem_q[rd_q].tag;
  assign bus.o_cdb_data  = mem_q[rd_q].data;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic compared
// against a queue-based model of the issue/broadcast behaviour.
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef ALU_SRC1_SEL
`define ALU_SRC1_SEL 2
`endif
`ifndef ALU_SRC2_SEL
`define ALU_SRC2_SEL 2
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module tb_alu_issue_ctrl;
  localparam int TAG_W = 6;
  localparam int DW    = `RV32_DATA_WIDTH;
  localparam int OPW   = `ALU_OP_SEL;
  localparam int S1W   = `ALU_SRC1_SEL;
  localparam int S2W   = `ALU_SRC2_SEL;
  localparam int PCW   = `RV32_PC_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus();
  alu_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } ent_t;

  int checks = 0;
  int failures = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  // reference model state
  ent_t q[$];
  bit   inf_v = 1'b0;
  ent_t inf_e;
  bit   ptr_m = 1'b0;
  bit   e_g0, e_g1, e_cv;
  ent_t e_head;

  // Behavioural ALU: op 0 is ADD (src2 = imm when s2sel==1), others mix every field.
  function automatic logic [DW-1:0] alu_ref(logic [OPW-1:0] op, logic [S1W-1:0] s1,
      logic [S2W-1:0] s2, logic [DW-1:0] rs1, logic [DW-1:0] rs2, logic [DW-1:0] imm,
      logic [PCW-1:0] pc);
    if (op == '0) return (s2 == S2W'(1)) ? rs1 + imm : rs1 + rs2;
    return rs1 ^ (rs2 << 1) ^ (imm - DW'(pc)) ^ DW'({op, s1, s2});
  endfunction

  always_comb bus.i_alu_res = alu_ref(bus.o_alu_op, bus.o_alu_s1sel, bus.o_alu_s2sel,
                                      bus.o_alu_rs1, bus.o_alu_rs2, bus.o_alu_imm, bus.o_alu_pc);

  function automatic ent_t req_ent(bit n);
    ent_t e;
    if (!n) begin
      e.tag  = bus.i_tag0;
      e.data = alu_ref(bus.i_op0, bus.i_s1sel0, bus.i_s2sel0, bus.i_rs10, bus.i_rs20, bus.i_imm0, bus.i_pc0);
    end else begin
      e.tag  = bus.i_tag1;
      e.data = alu_ref(bus.i_op1, bus.i_s1sel1, bus.i_s2sel1, bus.i_rs11, bus.i_rs21, bus.i_imm1, bus.i_pc1);
    end
    return e;
  endfunction

  // Expected combinational outputs for the current model state and inputs.
  function automatic void model_comb();
    int pop, occ;
    bit ok;
    e_cv = !rst && (q.size() != 0);
    pop  = (e_cv && bus.i_cdb_rdy) ? 1 : 0;
    occ  = q.size() + int'(inf_v) - pop;
    ok   = !rst && !bus.i_flush && (occ < 2);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (ok) begin
      if (bus.i_req0 && bus.i_req1) begin
        if (ptr_m) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else if (bus.i_req0) e_g0 = 1'b1;
      else if (bus.i_req1) e_g1 = 1'b1;
    end
    if (e_cv) e_head = q[0];
  endfunction

  task automatic settle();
    @(negedge clk);
    model_comb();
  endtask

  task automatic advance();
    if (rst) begin
      q.delete(); inf_v = 1'b0; ptr_m = 1'b0;
    end else if (bus.i_flush) begin
      q.delete(); inf_v = 1'b0;
    end else begin
      if (e_cv && bus.i_cdb_rdy) void'(q.pop_front());
      if (inf_v) q.push_back(inf_e);
      inf_v = e_g0 | e_g1;
      if (e_g0) begin inf_e = req_ent(1'b0); ptr_m = 1'b1; end
      if (e_g1) begin inf_e = req_ent(1'b1); ptr_m = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pay();
    bus.i_op0 = OPW'($urandom);       bus.i_op1 = OPW'($urandom);
    bus.i_s1sel0 = S1W'($urandom);    bus.i_s1sel1 = S1W'($urandom);
    bus.i_s2sel0 = S2W'($urandom);    bus.i_s2sel1 = S2W'($urandom);
    bus.i_rs10 = DW'($urandom);       bus.i_rs11 = DW'($urandom);
    bus.i_rs20 = DW'($urandom);       bus.i_rs21 = DW'($urandom);
    bus.i_imm0 = DW'($urandom);       bus.i_imm1 = DW'($urandom);
    bus.i_pc0 = PCW'($urandom);       bus.i_pc1 = PCW'($urandom);
    bus.i_tag0 = tag_ctr;             bus.i_tag1 = tag_ctr + 1'b1;
    tag_ctr = tag_ctr + 2'd2;
  endtask

  task automatic drain();
    bus.i_req0 = 0; bus.i_req1 = 0; bus.i_flush = 0; bus.i_cdb_rdy = 1;
    repeat (4) begin settle(); advance(); end
  endtask

  task automatic test_reset();
    rst = 1; bus.i_req0 = 1; bus.i_req1 = 1; bus.i_cdb_rdy = 1; bus.i_flush = 0;
    rand_pay();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (bus.o_gnt0 !== 1'b0 || bus.o_gnt1 !== 1'b0) begin
        failures++; $display("FAIL reset_gnt got=%b%b exp=00", bus.o_gnt0, bus.o_gnt1);
      end
      checks++;
      if (bus.o_alu_vld !== 1'b0 || bus.o_cdb_vld !== 1'b0) begin
        failures++; $display("FAIL reset_vld alu=%b cdb=%b exp=0 0", bus.o_alu_vld, bus.o_cdb_vld);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] tq[$];
    logic [TAG_W-1:0] et;
    rst = 0; bus.i_req0 = 1; bus.i_req1 = 1; bus.i_cdb_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      rand_pay();
      settle();
      tq.push_back((i % 2 == 0) ? bus.i_tag0 : bus.i_tag1);
      checks++;
      if (bus.o_gnt0 !== (i % 2 == 0) || bus.o_gnt1 !== (i % 2 == 1)) begin
        failures++; $display("FAIL b2b_gnt cyc=%0d got=%b%b exp=%b%b", i, bus.o_gnt0, bus.o_gnt1, i % 2 == 0, i % 2 == 1);
      end
      checks++;
      if (bus.o_cdb_vld !== (i >= 2)) begin
        failures++; $display("FAIL b2b_cdb_vld cyc=%0d got=%b exp=%b", i, bus.o_cdb_vld, i >= 2);
      end
      if (i >= 2) begin
        et = tq.pop_front();
        checks++;
        if (bus.o_cdb_tag !== et || bus.o_cdb_data !== e_head.data) begin
          failures++; $display("FAIL b2b_cdb cyc=%0d tag=%0d/%0d data=%h/%h", i, bus.o_cdb_tag, et, bus.o_cdb_data, e_head.data);
        end
      end
      advance();
    end
  endtask

  task automatic test_single_req();
    bus.i_req0 = 0; bus.i_req1 = 1; bus.i_cdb_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      rand_pay(); settle();
      checks++;
      if (bus.o_gnt1 !== 1'b1 || bus.o_gnt0 !== 1'b0) begin
        failures++; $display("FAIL single_req1 cyc=%0d got=%b%b exp=01", i, bus.o_gnt0, bus.o_gnt1);
      end
      advance();
    end
    bus.i_req0 = 1; rand_pay(); settle();
    checks++;
    if (bus.o_gnt0 !== 1'b1 || bus.o_gnt1 !== 1'b0) begin
      failures++; $display("FAIL single_then_both got=%b%b exp=10", bus.o_gnt0, bus.o_gnt1);
    end
    advance();
  endtask

  task automatic test_add();
    drain();
    rand_pay();
    bus.i_req0 = 1; bus.i_op0 = '0; bus.i_s2sel0 = S2W'(1); bus.i_rs10 = 5; bus.i_imm0 = 7;
    bus.i_rs20 = 0; bus.i_pc0 = 0; bus.i_tag0 = 3;
    settle();
    checks++;
    if (bus.o_gnt0 !== 1'b1) begin failures++; $display("FAIL add_gnt got=%b exp=1", bus.o_gnt0); end
    advance();
    bus.i_req0 = 0; settle();
    checks++;
    if (bus.o_alu_vld !== 1'b1 || bus.o_cdb_vld !== 1'b0) begin
      failures++; $display("FAIL add_n1 alu_vld=%b cdb_vld=%b exp=1 0", bus.o_alu_vld, bus.o_cdb_vld);
    end
    advance();
    settle();
    checks++;
    if (bus.o_cdb_vld !== 1'b1 || bus.o_cdb_tag !== 6'd3 || bus.o_cdb_data !== DW'(12)) begin
      failures++; $display("FAIL add_n2 vld=%b tag=%0d data=%0d exp=1 3 12", bus.o_cdb_vld, bus.o_cdb_tag, bus.o_cdb_data);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int ngnt = 0;
    logic [TAG_W-1:0] rt;
    logic [DW-1:0] rd;
    drain();
    bus.i_req0 = 1; bus.i_req1 = 1; bus.i_cdb_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      rand_pay(); settle();
      if (bus.o_gnt0 | bus.o_gnt1) ngnt++;
      if (i == 2) begin
        rt = bus.o_cdb_tag; rd = bus.o_cdb_data;
        checks++;
        if (bus.o_cdb_vld !== 1'b1 || rt !== e_head.tag || rd !== e_head.data) begin
          failures++; $display("FAIL bp_head vld=%b tag=%0d/%0d", bus.o_cdb_vld, rt, e_head.tag);
        end
      end else if (i > 2) begin
        checks++;
        if (bus.o_cdb_vld !== 1'b1 || bus.o_cdb_tag !== rt || bus.o_cdb_data !== rd) begin
          failures++; $display("FAIL bp_stable cyc=%0d vld=%b tag=%0d/%0d", i, bus.o_cdb_vld, bus.o_cdb_tag, rt);
        end
      end
      advance();
    end
    checks++;
    if (ngnt !== 2) begin failures++; $display("FAIL bp_grants got=%0d exp=2", ngnt); end
    bus.i_cdb_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      rand_pay(); settle();
      checks++;
      if ((bus.o_gnt0 | bus.o_gnt1) !== 1'b1 || bus.o_cdb_vld !== 1'b1) begin
        failures++; $display("FAIL bp_resume cyc=%0d gnt=%b%b cdb_vld=%b exp=grant,1", i, bus.o_gnt0, bus.o_gnt1, bus.o_cdb_vld);
      end
      advance();
    end
  endtask

  task automatic test_flush();
    drain();
    bus.i_req0 = 1; bus.i_req1 = 1; bus.i_cdb_rdy = 0;
    repeat (2) begin rand_pay(); settle(); advance(); end
    bus.i_cdb_rdy = 1; bus.i_flush = 1; rand_pay(); settle();
    checks++;
    if (bus.o_gnt0 !== 1'b0 || bus.o_gnt1 !== 1'b0) begin
      failures++; $display("FAIL flush_gnt got=%b%b exp=00", bus.o_gnt0, bus.o_gnt1);
    end
    advance();
    bus.i_flush = 0;
    for (int i = 0; i < 5; i++) begin
      rand_pay(); settle();
      if (i == 0) begin
        checks++;
        if (bus.o_alu_vld !== 1'b0 || bus.o_cdb_vld !== 1'b0) begin
          failures++; $display("FAIL flush_clear alu_vld=%b cdb_vld=%b exp=0 0", bus.o_alu_vld, bus.o_cdb_vld);
        end
      end
      checks++;
      if (bus.o_gnt0 !== e_g0 || bus.o_gnt1 !== e_g1 || bus.o_cdb_vld !== e_cv) begin
        failures++; $display("FAIL flush_after cyc=%0d gnt=%b%b/%b%b cdb=%b/%b", i, bus.o_gnt0, bus.o_gnt1, e_g0, e_g1, bus.o_cdb_vld, e_cv);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drain();
    bus.i_req0 = 1; bus.i_req1 = 0; bus.i_cdb_rdy = 0;
    repeat (2) begin rand_pay(); settle(); advance(); end
    rst = 1; settle();
    checks++;
    if (bus.o_cdb_vld !== 1'b0 || bus.o_gnt0 !== 1'b0) begin
      failures++; $display("FAIL rstmid_during cdb_vld=%b gnt0=%b exp=0 0", bus.o_cdb_vld, bus.o_gnt0);
    end
    advance();
    rst = 0; bus.i_req0 = 0; bus.i_cdb_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (bus.o_alu_vld !== 1'b0 || bus.o_cdb_vld !== 1'b0 || bus.o_gnt0 !== 1'b0 || bus.o_gnt1 !== 1'b0) begin
        failures++; $display("FAIL rstmid_after cyc=%0d alu=%b cdb=%b gnt=%b%b exp=0 0 00", i, bus.o_alu_vld, bus.o_cdb_vld, bus.o_gnt0, bus.o_gnt1);
      end
      advance();
    end
    bus.i_req0 = 1; bus.i_req1 = 1; rand_pay(); settle();
    checks++;
    if (bus.o_gnt0 !== 1'b1 || bus.o_gnt1 !== 1'b0) begin
      failures++; $display("FAIL rstmid_first got=%b%b exp=10", bus.o_gnt0, bus.o_gnt1);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_pay();
      bus.i_req0    = ($urandom_range(0, 99) < 60);
      bus.i_req1    = ($urandom_range(0, 99) < 60);
      bus.i_cdb_rdy = ($urandom_range(0, 99) < 70);
      bus.i_flush   = ($urandom_range(0, 99) < 3);
      settle();
      checks++;
      if (bus.o_gnt0 !== e_g0 || bus.o_gnt1 !== e_g1) begin
        failures++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", i, bus.o_gnt0, bus.o_gnt1, e_g0, e_g1);
      end
      checks++;
      if (bus.o_alu_vld !== inf_v || bus.o_cdb_vld !== e_cv) begin
        failures++; $display("FAIL rnd_vld cyc=%0d alu=%b/%b cdb=%b/%b", i, bus.o_alu_vld, inf_v, bus.o_cdb_vld, e_cv);
      end
      if (e_cv) begin
        checks++;
        if (bus.o_cdb_tag !== e_head.tag || bus.o_cdb_data !== e_head.data) begin
          failures++; $display("FAIL rnd_cdb cyc=%0d tag=%0d/%0d data=%h/%h", i, bus.o_cdb_tag, e_head.tag, bus.o_cdb_data, e_head.data);
        end
      end
      advance();
    end
    bus.i_flush = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_req();
    test_add();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
